// File: rtl/adam_axil_to_obi_pkg.sv
// Shared types and constants for the AXI-Lite to OBI responder.
package adam_axil_to_obi_pkg;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_AXRSP,
    ST_PAUSED
  } state_e;

  // The bridge never reports errors
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/adam_axil_to_obi_arb.sv
// Read/write arbiter for the AXI-Lite to OBI responder.
// Build option: ADAM_AXIL_TO_OBI_RR_EN selects round-robin, otherwise reads win.
module adam_axil_to_obi_arb (
  input  logic clk,
  input  logic rst,
  input  logic rd_valid,
  input  logic wr_valid,
  input  logic advance,
  output logic grant_rd_c,
  output logic grant_wr_c
);

`ifdef ADAM_AXIL_TO_OBI_RR_EN
  // Remembers the kind served last; resets as "write" so a first collision serves the read
  logic last_wr;

  // Update the last-served flag whenever a transaction is launched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_wr <= 1'b1;
    end else if (advance) begin
      last_wr <= grant_wr_c;
    end
  end

  // On a collision the opposite kind of the last one wins
  always_comb begin
    grant_rd_c = rd_valid && (!wr_valid || last_wr);
    grant_wr_c = wr_valid && (!rd_valid || !last_wr);
  end
`else
  // Fixed priority needs no state
  logic unused_rr;
  assign unused_rr = ^{clk, rst, advance};

  // Reads always win; writes go only when no read is waiting
  always_comb begin
    grant_rd_c = rd_valid;
    grant_wr_c = wr_valid && !rd_valid;
  end
`endif

endmodule

// File: rtl/adam_axil_to_obi.sv
// AXI-Lite responder issuing one OBI initiator transaction per AXI-Lite access.
// Build option: ADAM_AXIL_TO_OBI_RR_EN enables round-robin read/write arbitration.
module adam_axil_to_obi
  import adam_axil_to_obi_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause_req,
  output logic                  pause_ack,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata_axil,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata_axil,
  output logic [1:0]            rresp,
  output logic                  rvalid_axil,
  input  logic                  rready_axil,
  output logic                  req,
  input  logic                  gnt,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  we,
  output logic [STRB_WIDTH-1:0] be,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata
);

  state_e                state;
  logic                  aw_full, w_full;
  logic                  aw_full_nxt, w_full_nxt;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  aw_hs, w_hs, wr_pend, serve, advance, free_wr, go_pause;
  logic                  grant_rd_c, grant_wr_c;

  assign bresp = RESP_OKAY;
  assign rresp = RESP_OKAY;

  // Handshake detection, pending write (including this cycle's captures) and AR acceptance
  always_comb begin
    aw_hs       = awvalid && awready;
    w_hs        = wvalid && wready;
    wr_pend     = (aw_full || aw_hs) && (w_full || w_hs);
    serve       = (state == ST_IDLE) && !pause_req;
    advance     = serve && (grant_rd_c || grant_wr_c);
    free_wr     = (state == ST_RESP) && rvalid && we;
    go_pause    = pause_req && ((state == ST_IDLE) || (state == ST_PAUSED));
    aw_full_nxt = !free_wr && (aw_full || aw_hs);
    w_full_nxt  = !free_wr && (w_full || w_hs);
    arready     = serve && grant_rd_c && !rst;
  end

  adam_axil_to_obi_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .rd_valid  (serve && arvalid),
    .wr_valid  (serve && wr_pend),
    .advance   (advance),
    .grant_rd_c(grant_rd_c),
    .grant_wr_c(grant_wr_c)
  );

  // AW/W holding registers, freed when the OBI write response arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready   <= 1'b0;
      wready    <= 1'b0;
    end else begin
      aw_full <= aw_full_nxt;
      w_full  <= w_full_nxt;
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata_axil;
        w_strb_q <= wstrb;
      end
      awready <= !aw_full_nxt && !go_pause;
      wready  <= !w_full_nxt && !go_pause;
    end
  end

  // Transaction sequencer with registered OBI, AXI response and pause outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      req         <= 1'b0;
      we          <= 1'b0;
      addr        <= '0;
      be          <= '0;
      wdata       <= '0;
      rready      <= 1'b0;
      bvalid      <= 1'b0;
      rvalid_axil <= 1'b0;
      rdata_axil  <= '0;
      pause_ack   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pause_req) begin
            pause_ack <= 1'b1;
            state     <= ST_PAUSED;
          end else if (grant_rd_c) begin
            addr  <= araddr;
            we    <= 1'b0;
            be    <= '1;
            wdata <= '0;
            req   <= 1'b1;
            state <= ST_REQ;
          end else if (grant_wr_c) begin
            addr  <= aw_full ? aw_addr_q : awaddr;
            we    <= 1'b1;
            be    <= w_full ? w_strb_q : wstrb;
            wdata <= w_full ? w_data_q : wdata_axil;
            req   <= 1'b1;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (gnt) begin
            req    <= 1'b0;
            rready <= 1'b1;
            state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (we) begin
              bvalid <= 1'b1;
            end else begin
              rvalid_axil <= 1'b1;
              rdata_axil  <= rdata;
            end
            state <= ST_AXRSP;
          end
        end
        ST_AXRSP: begin
          if ((rvalid_axil && rready_axil) || (bvalid && bready)) begin
            rvalid_axil <= 1'b0;
            bvalid      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_PAUSED: begin
          if (!pause_req) begin
            pause_ack <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adam_axil_to_obi.sv
// Directed self-checking bench for adam_axil_to_obi with a behavioural OBI memory.
module tb_adam_axil_to_obi;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause_req, pause_ack;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata_axil;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata_axil;
  logic [1:0]  rresp;
  logic        rvalid_axil, rready_axil;
  logic        req, gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid, rready;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  adam_axil_to_obi dut (
    .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata_axil(wdata_axil), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata_axil(rdata_axil), .rresp(rresp), .rvalid_axil(rvalid_axil), .rready_axil(rready_axil),
    .req(req), .gnt(gnt), .addr(addr), .we(we), .be(be), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .rdata(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- OBI memory model ----------------
  logic [31:0] mem [logic [31:0]];
  int          gnt_dly = 0, rv_dly = 0;
  int          m_phase = 0, m_cnt = 0;
  logic [31:0] m_rd;
  logic [31:0] log_addr [$];
  logic        log_we   [$];
  logic [3:0]  log_be   [$];
  logic [31:0] log_wd   [$];
  int          req_hi_cycles = 0;
  bit          stab_err = 0;
  bit          s_valid = 0;
  logic [68:0] s_snap;

  always @(negedge clk) begin
    if (rst) begin
      gnt = 1'b0; rvalid = 1'b0; rdata = '0; m_phase = 0; m_cnt = 0; s_valid = 0;
    end else begin
      case (m_phase)
        0: if (req) begin
          req_hi_cycles++;
          if (!s_valid) begin s_snap = {addr, we, be, wdata}; s_valid = 1; end
          else if ({addr, we, be, wdata} !== s_snap) stab_err = 1;
          if (m_cnt >= gnt_dly) begin
            gnt = 1'b1;
            log_addr.push_back(addr); log_we.push_back(we);
            log_be.push_back(be); log_wd.push_back(wdata);
            m_rd = mem.exists(addr) ? mem[addr] : 32'h0;
            if (we) begin
              for (int b = 0; b < 4; b++) if (be[b]) m_rd[8*b +: 8] = wdata[8*b +: 8];
              mem[addr] = m_rd;
            end
            m_phase = 1; m_cnt = 0;
          end else m_cnt++;
        end
        1: begin
          gnt = 1'b0; s_valid = 0;
          if (m_cnt >= rv_dly) begin rvalid = 1'b1; rdata = m_rd; m_phase = 2; end
          else m_cnt++;
        end
        default: begin rvalid = 1'b0; rdata = '0; m_phase = 0; m_cnt = 0; end
      endcase
    end
  end

  // ---------------- AXI-Lite drivers (entered and left at posedge+1) ----------------
  task automatic do_ar(input logic [31:0] a, output int hs, output bit ok);
    ok = 0; hs = -1; araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      #1;
      if (arready) begin hs = cyc; ok = 1; end
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
  endtask

  task automatic do_r(input int hold, output logic [31:0] d, output logic [1:0] r,
                      output int vc, output bit ok, output bit held_ok);
    ok = 0; held_ok = 1; vc = -1; d = '0; r = 2'b11;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (rvalid_axil) begin ok = 1; vc = cyc; d = rdata_axil; r = rresp; end
      else begin @(posedge clk); #1; end
    end
    if (ok) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!rvalid_axil || rdata_axil !== d) held_ok = 0;
      end
      rready_axil = 1'b1;
      @(posedge clk); #1;
      rready_axil = 1'b0;
    end
  endtask

  task automatic do_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int w_lead, output int last_hs, output bit ok);
    bit aw_done = 0, w_done = 0;
    last_hs = -1; awaddr = a; wdata_axil = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 300 && !(aw_done && w_done); i++) begin
      awvalid = !aw_done && (i >= w_lead);
      #1;
      if (awvalid && awready) begin aw_done = 1; last_hs = cyc; end
      if (wvalid && wready) begin w_done = 1; last_hs = cyc; end
      @(posedge clk); #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    ok = aw_done && w_done;
  endtask

  task automatic do_b(output logic [1:0] r, output int vc, output bit ok);
    ok = 0; vc = -1; r = 2'b11;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bvalid) begin ok = 1; vc = cyc; r = bresp; end
      else begin @(posedge clk); #1; end
    end
    if (ok) begin
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({req, we, rready, awready, wready, arready, bvalid, rvalid_axil, pause_ack} !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=000000000",
        {req, we, rready, awready, wready, arready, bvalid, rvalid_axil, pause_ack});
    end
    n_tests++;
    if ({addr, be, wdata, rdata_axil} !== 100'b0) begin
      n_fail++; $display("FAIL reset_data addr=%h be=%h wdata=%h rdata=%h exp all 0", addr, be, wdata, rdata_axil);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({awready, wready} !== 2'b00) begin
      n_fail++; $display("FAIL ready_at_release got=%b exp=00", {awready, wready});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({awready, wready} !== 2'b11) begin
      n_fail++; $display("FAIL ready_after_release got=%b exp=11", {awready, wready});
    end
  endtask

  task automatic test_single_read();
    int hs, vc, n0; bit ok, rok, held; logic [31:0] d; logic [1:0] r;
    n0 = log_addr.size();
    do_ar(32'h1000, hs, ok);
    do_r(0, d, r, vc, rok, held);
    n_tests++;
    if (!(ok && rok)) begin n_fail++; $display("FAIL read_timeout ar=%0d r=%0d exp 1 1", ok, rok); end
    n_tests++;
    if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data got=%h exp=deadbeef", d); end
    n_tests++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL read_resp got=%b exp=00", r); end
    n_tests++;
    if (vc - hs !== 3) begin n_fail++; $display("FAIL read_latency got=%0d exp=3", vc - hs); end
    n_tests++;
    if (log_addr.size() !== n0 + 1 || log_addr[n0] !== 32'h1000 || log_we[n0] !== 1'b0
        || log_be[n0] !== 4'hF || log_wd[n0] !== 32'h0) begin
      n_fail++; $display("FAIL read_obi n=%0d addr=%h we=%b be=%h wd=%h exp 1 1000 0 f 0",
        log_addr.size() - n0, log_addr[n0], log_we[n0], log_be[n0], log_wd[n0]);
    end
  endtask

  task automatic test_write_w_first();
    int hs, vc, n0, hs2, vc2; bit ok, bok, rok, held; logic [1:0] r; logic [31:0] d;
    n0 = log_addr.size();
    do_w(32'h2004, 32'hA5A5A5A5, 4'b0011, 2, hs, ok);
    do_b(r, vc, bok);
    n_tests++;
    if (!(ok && bok)) begin n_fail++; $display("FAIL write_timeout w=%0d b=%0d exp 1 1", ok, bok); end
    n_tests++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL write_bresp got=%b exp=00", r); end
    n_tests++;
    if (vc - hs !== 3) begin n_fail++; $display("FAIL write_latency got=%0d exp=3", vc - hs); end
    n_tests++;
    if (log_addr.size() !== n0 + 1 || log_addr[n0] !== 32'h2004 || log_we[n0] !== 1'b1
        || log_be[n0] !== 4'b0011 || log_wd[n0] !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL write_obi n=%0d addr=%h we=%b be=%h wd=%h exp 1 2004 1 3 a5a5a5a5",
        log_addr.size() - n0, log_addr[n0], log_we[n0], log_be[n0], log_wd[n0]);
    end
    n_tests++;
    if (bvalid !== 1'b0) begin n_fail++; $display("FAIL bvalid_once got=%b exp=0", bvalid); end
    do_ar(32'h2004, hs2, ok);
    do_r(0, d, r, vc2, rok, held);
    n_tests++;
    if (d !== 32'h0000A5A5) begin n_fail++; $display("FAIL write_readback got=%h exp=0000a5a5", d); end
  endtask

  task automatic test_wait_states();
    int hs, vc, n0; bit ok, rok, held, bok; logic [31:0] d; logic [1:0] r;
    gnt_dly = 4; rv_dly = 3; stab_err = 0; req_hi_cycles = 0;
    n0 = log_addr.size();
    do_ar(32'h1000, hs, ok);
    do_r(5, d, r, vc, rok, held);
    n_tests++;
    if (d !== 32'hDEADBEEF || !rok) begin n_fail++; $display("FAIL ws_read_data got=%h exp=deadbeef", d); end
    n_tests++;
    if (held !== 1'b1) begin n_fail++; $display("FAIL ws_r_hold got=%b exp=1", held); end
    n_tests++;
    if (req_hi_cycles !== 5) begin n_fail++; $display("FAIL ws_req_cycles got=%0d exp=5", req_hi_cycles); end
    n_tests++;
    if (log_addr.size() - n0 !== 1) begin n_fail++; $display("FAIL ws_one_txn got=%0d exp=1", log_addr.size() - n0); end
    do_w(32'h2008, 32'h12345678, 4'hF, 0, hs, ok);
    do_b(r, vc, bok);
    n_tests++;
    if (stab_err !== 1'b0) begin n_fail++; $display("FAIL ws_req_stable got=%b exp=0", stab_err); end
    n_tests++;
    if (!bok || mem[32'h2008] !== 32'h12345678) begin
      n_fail++; $display("FAIL ws_write_mem got=%h exp=12345678", mem[32'h2008]);
    end
    gnt_dly = 0; rv_dly = 0;
  endtask

  task automatic test_arbitration();
    int n0; logic [7:0] order, exp_order; logic [31:0] got;
    n0 = log_addr.size();
    for (int k = 0; k < 4; k++) mem[32'h3000 + 32'(4 * k)] = 32'h11111111 * 32'(k + 1);
    fork
      begin
        int hs, vc; bit ok, rok, held; logic [31:0] d; logic [1:0] r;
        for (int k = 0; k < 4; k++) begin
          do_ar(32'h3000 + 32'(4 * k), hs, ok);
          do_r(0, d, r, vc, rok, held);
          n_tests++;
          if (d !== 32'h11111111 * 32'(k + 1)) begin
            n_fail++; $display("FAIL arb_read%0d got=%h exp=%h", k, d, 32'h11111111 * 32'(k + 1));
          end
        end
      end
      begin
        int hs, vc; bit ok, bok; logic [1:0] r;
        for (int k = 0; k < 4; k++) begin
          do_w(32'h4000 + 32'(4 * k), 32'hC0DE0000 | 32'(k), 4'hF, 0, hs, ok);
          do_b(r, vc, bok);
        end
      end
    join
    order = '0;
    for (int i = 0; i < 8; i++) if (n0 + i < log_we.size()) order[i] = log_we[n0 + i];
`ifdef ADAM_AXIL_TO_OBI_RR_EN
    exp_order = 8'b10101010;
`else
    exp_order = 8'b11110000;
`endif
    n_tests++;
    if (order !== exp_order || log_we.size() - n0 !== 8) begin
      n_fail++; $display("FAIL arb_order got=%b n=%0d exp=%b n=8", order, log_we.size() - n0, exp_order);
    end
    for (int k = 0; k < 4; k++) begin
      got = mem.exists(32'h4000 + 32'(4 * k)) ? mem[32'h4000 + 32'(4 * k)] : 32'h0;
      n_tests++;
      if (got !== (32'hC0DE0000 | 32'(k))) begin
        n_fail++; $display("FAIL arb_write%0d got=%h exp=%h", k, got, 32'hC0DE0000 | 32'(k));
      end
    end
  endtask

  task automatic test_pause();
    int hs, vc, seen; bit ok, rok, held, got_resp, got_ack; logic [31:0] d; logic [1:0] r;
    rv_dly = 3;
    do_ar(32'h1000, hs, ok);
    got_resp = 0;
    for (int i = 0; i < 20 && !got_resp; i++) begin
      if (rready) got_resp = 1; else begin @(posedge clk); #1; end
    end
    pause_req = 1'b1;
    do_r(0, d, r, vc, rok, held);
    n_tests++;
    if (!got_resp || !rok || d !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL pause_completes resp=%0d r=%0d data=%h exp 1 1 deadbeef", got_resp, rok, d);
    end
    rv_dly = 0;
    got_ack = 0;
    for (int i = 0; i < 5 && !got_ack; i++) begin
      if (pause_ack) got_ack = 1; else begin @(posedge clk); #1; end
    end
    n_tests++;
    if (got_ack !== 1'b1) begin n_fail++; $display("FAIL pause_ack got=%b exp=1", got_ack); end
    araddr = 32'h1000; arvalid = 1'b1; seen = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (arready || awready || wready || !pause_ack) seen++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL pause_blocks got=%0d exp=0", seen); end
    pause_req = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (pause_ack !== 1'b0) begin n_fail++; $display("FAIL pause_release got=%b exp=0", pause_ack); end
    do_ar(32'h1000, hs, ok);
    do_r(0, d, r, vc, rok, held);
    n_tests++;
    if (!ok || d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pause_after_read got=%h exp=deadbeef", d); end
  endtask

  task automatic test_reset_mid();
    int hs, vc; bit ok, rok, held; logic [31:0] d; logic [1:0] r;
    gnt_dly = 6;
    do_ar(32'h1000, hs, ok);
    n_tests++;
    if (req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_before got=%b exp=1", req); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_async got=%b exp=0", req); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    gnt_dly = 0;
    @(posedge clk); #1;
    do_ar(32'h1000, hs, ok);
    do_r(0, d, r, vc, rok, held);
    n_tests++;
    if (!ok || !rok || d !== 32'hDEADBEEF || vc - hs !== 3) begin
      n_fail++; $display("FAIL rstmid_fresh_read data=%h lat=%0d exp deadbeef 3", d, vc - hs);
    end
  endtask

  initial begin
    rst = 1'b1; pause_req = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata_axil = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready_axil = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    mem[32'h1000] = 32'hDEADBEEF;
    test_reset();
    test_single_read();
    test_write_w_first();
    test_wait_states();
    test_arbitration();
    test_pause();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
